// File: rtl/sar_search8.sv
// sar_search8 -- successive-approximation search controller.
//
// Drives a trial operand (guess) to an external comparator and resolves the
// comparator's target one bit per cycle, MSB first. A search starts from
// guess = 100..0 and either exits early on an equal result, completes after
// DATA_W trial cycles, or aborts with err on an invalid comparator code.
//
// Ports:
//   clk    : rising-edge clock for all state
//   rst    : synchronous active-high reset (priority over everything)
//   start  : request a new search, sampled only in IDLE
//   cmp    : comparator result {target>guess, target==guess, target<guess}
//   guess  : registered trial operand
//   busy   : high while trying bits
//   done   : one-cycle pulse when a search ends
//   result : resolved target, held until the next accepted start
//   err    : set with done on an invalid cmp code, held until next start
module sar_search8 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        cmp,
  output logic [DATA_W-1:0] guess,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] GUESS_INIT = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]  IDX_MSB    = IDX_W'(DATA_W - 1);

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  typedef enum logic [1:0] {
    IDLE,
    TRY,
    DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [DATA_W-1:0] guess_next;

  // Resolve the bit under test (keep on GT, clear on LT) and, if lower bits
  // remain, raise the next trial bit. At idx==0 this is the final answer.
  always_comb begin
    guess_next = guess;
    if (cmp == CMP_LT) begin
      guess_next[idx] = 1'b0;
    end
    if (idx != '0) begin
      guess_next[idx - IDX_W'(1)] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      guess  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          guess <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            state  <= TRY;
            guess  <= GUESS_INIT;
            idx    <= IDX_MSB;
            result <= '0;
            err    <= 1'b0;
            busy   <= 1'b1;
          end
        end

        TRY: begin
          case (cmp)
            CMP_EQ: begin
              state  <= DONE;
              result <= guess;
              err    <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
            CMP_GT, CMP_LT: begin
              if (idx != '0) begin
                guess <= guess_next;
                idx   <= idx - IDX_W'(1);
              end else begin
                state  <= DONE;
                guess  <= guess_next;
                result <= guess_next;
                err    <= 1'b0;
                busy   <= 1'b0;
                done   <= 1'b1;
              end
            end
            default: begin
              // Non-one-hot comparator code: abort the search.
              state  <= DONE;
              result <= '0;
              err    <= 1'b1;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          endcase
        end

        DONE: begin
          // start is deliberately not examined here; it is not queued.
          state <= IDLE;
          idx   <= '0;
          guess <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          idx   <= '0;
          guess <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search8.sv
// tb_sar_search8 -- directed bench for sar_search8. A behavioural comparator
// evaluates a target against the DUT's guess; an override can force arbitrary
// cmp codes. Outputs are checked 1 time unit after each rising edge.
module tb_sar_search8;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] cmp;
  logic [7:0] guess;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       err;

  logic [7:0] target;
  logic       force_en;
  logic [2:0] force_val;

  int vectors;
  int miscompares;

  sar_search8 dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp    (cmp),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model
  always_comb begin
    if (force_en)             cmp = force_val;
    else if (target > guess)  cmp = 3'b100;
    else if (target == guess) cmp = 3'b010;
    else                      cmp = 3'b001;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    tick();
    tick();
    vectors++;
    if ({guess, busy, done, result, err} !== {8'h00, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got guess=%h busy=%b done=%b result=%h err=%b, want all zero",
               guess, busy, done, result, err);
    end
    start = 1'b0;
    rst = 1'b0;
    tick();
    vectors++;
    if ({guess, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL idle_after_reset: got guess=%h busy=%b done=%b, want 00 0 0", guess, busy, done);
    end
  endtask

  task automatic test_t80();
    target = 8'h80;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({guess, busy, done} !== {8'h80, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL t80_cycle1: got guess=%h busy=%b done=%b, want 80 1 0", guess, busy, done);
    end
    tick();
    vectors++;
    if ({done, busy, err, result} !== {1'b1, 1'b0, 1'b0, 8'h80}) begin
      miscompares++;
      $display("FAIL t80_done: got done=%b busy=%b err=%b result=%h, want 1 0 0 80",
               done, busy, err, result);
    end
    tick();
    vectors++;
    if ({done, busy, guess, result} !== {1'b0, 1'b0, 8'h00, 8'h80}) begin
      miscompares++;
      $display("FAIL t80_idle: got done=%b busy=%b guess=%h result=%h, want 0 0 00 80",
               done, busy, guess, result);
    end
  endtask

  task automatic test_t00();
    logic [7:0] eg [8];
    eg = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    target = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if ({guess, busy, done} !== {eg[i], 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL t00_cycle%0d: got guess=%h busy=%b done=%b, want %h 1 0",
                 i + 1, guess, busy, done, eg[i]);
      end
      tick();
    end
    vectors++;
    if ({done, busy, err, result} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL t00_done: got done=%b busy=%b err=%b result=%h, want 1 0 0 00",
               done, busy, err, result);
    end
    tick();
  endtask

  task automatic test_tff();
    logic [7:0] eg [8];
    eg = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    target = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if ({guess, busy, done} !== {eg[i], 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL tff_cycle%0d: got guess=%h busy=%b done=%b, want %h 1 0",
                 i + 1, guess, busy, done, eg[i]);
      end
      tick();
    end
    vectors++;
    if ({done, busy, err, result} !== {1'b1, 1'b0, 1'b0, 8'hFF}) begin
      miscompares++;
      $display("FAIL tff_done: got done=%b busy=%b err=%b result=%h, want 1 0 0 FF",
               done, busy, err, result);
    end
    tick();
  endtask

  task automatic test_t02_ignored_start();
    logic [7:0] eg [7];
    eg = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
    target = 8'h02;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if ({guess, busy, done} !== {eg[i], 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL t02_cycle%0d: got guess=%h busy=%b done=%b, want %h 1 0",
                 i + 1, guess, busy, done, eg[i]);
      end
      start = (i == 2);  // start held during cycle 3 only
      tick();
    end
    start = 1'b0;
    vectors++;
    if ({done, busy, err, result} !== {1'b1, 1'b0, 1'b0, 8'h02}) begin
      miscompares++;
      $display("FAIL t02_done: got done=%b busy=%b err=%b result=%h, want 1 0 0 02",
               done, busy, err, result);
    end
    start = 1'b1;  // re-pulse during DONE cycle 8
    tick();
    start = 1'b0;
    for (int i = 9; i < 11; i++) begin
      vectors++;
      if ({busy, done, guess, result} !== {1'b0, 1'b0, 8'h00, 8'h02}) begin
        miscompares++;
        $display("FAIL t02_no_restart_cycle%0d: got busy=%b done=%b guess=%h result=%h, want 0 0 00 02",
                 i, busy, done, guess, result);
      end
      tick();
    end
  endtask

  task automatic test_invalid_cmp();
    target = 8'h80;
    start = 1'b1;
    tick();
    start = 1'b0;
    force_en = 1'b1;
    force_val = 3'b000;
    tick();
    force_en = 1'b0;
    vectors++;
    if ({done, busy, err, result} !== {1'b1, 1'b0, 1'b1, 8'h00}) begin
      miscompares++;
      $display("FAIL err000_done: got done=%b busy=%b err=%b result=%h, want 1 0 1 00",
               done, busy, err, result);
    end
    tick();
    vectors++;
    if ({done, err} !== {1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL err_holds: got done=%b err=%b, want 0 1", done, err);
    end
    // Next start clears err; then abort mid-search with 3'b110.
    target = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, err, guess} !== {1'b1, 1'b0, 8'h80}) begin
      miscompares++;
      $display("FAIL err_cleared: got busy=%b err=%b guess=%h, want 1 0 80", busy, err, guess);
    end
    tick();
    tick();
    force_en = 1'b1;
    force_val = 3'b110;
    tick();
    force_en = 1'b0;
    vectors++;
    if ({done, err, result} !== {1'b1, 1'b1, 8'h00}) begin
      miscompares++;
      $display("FAIL err110_done: got done=%b err=%b result=%h, want 1 1 00", done, err, result);
    end
    tick();
  endtask

  task automatic test_reset_mid_search();
    int n;
    target = 8'hF0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;  // cycle 4
    tick();
    rst = 1'b0;
    vectors++;
    if ({guess, busy, done, result, err} !== {8'h00, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL midrst_cycle5: got guess=%h busy=%b done=%b result=%h err=%b, want all zero",
               guess, busy, done, result, err);
    end
    start = 1'b1;  // cycle 6
    tick();
    start = 1'b0;
    vectors++;
    if ({done, busy, guess} !== {1'b0, 1'b1, 8'h80}) begin
      miscompares++;
      $display("FAIL midrst_restart: got done=%b busy=%b guess=%h, want 0 1 80", done, busy, guess);
    end
    n = 1;
    while (!done && n < 12) begin
      tick();
      n++;
    end
    vectors++;
    if (n !== 5) begin
      miscompares++;
      $display("FAIL midrst_latency: got done after %0d cycles, want 5", n);
    end
    vectors++;
    if ({done, err, result} !== {1'b1, 1'b0, 8'hF0}) begin
      miscompares++;
      $display("FAIL midrst_result: got done=%b err=%b result=%h, want 1 0 F0", done, err, result);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    target = 8'h80;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first_done: got done=%b, want 1", done);
    end
    tick();
    target = 8'hC0;
    start = 1'b1;  // IDLE cycle right after DONE
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, guess, result} !== {1'b1, 8'h80, 8'h00}) begin
      miscompares++;
      $display("FAIL b2b_accept: got busy=%b guess=%h result=%h, want 1 80 00", busy, guess, result);
    end
    tick();
    vectors++;
    if ({busy, guess} !== {1'b1, 8'hC0}) begin
      miscompares++;
      $display("FAIL b2b_second_guess: got busy=%b guess=%h, want 1 C0", busy, guess);
    end
    tick();
    vectors++;
    if ({done, result} !== {1'b1, 8'hC0}) begin
      miscompares++;
      $display("FAIL b2b_second_done: got done=%b result=%h, want 1 C0", done, result);
    end
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    start = 1'b0;
    target = 8'h00;
    force_en = 1'b0;
    force_val = 3'b000;
    tick();
    test_reset();
    test_t80();
    test_t00();
    test_tff();
    test_t02_ignored_start();
    test_invalid_cmp();
    test_reset_mid_search();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sar_search8.md
SAR_SEARCH8 -- requirements
Module: sar_search8

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request a new search; sampled only in IDLE.
REQ-005 cmp  input  3  result from the external 8-bit comparator: cmp[2] means target > guess, cmp[1] means target == guess, cmp[0] means target < guess; valid in the same cycle as guess.
REQ-006 guess  output  8  registered trial operand driven to the comparator's second input.
REQ-007 busy  output  1  high while in TRY.
REQ-008 done  output  1  one-cycle pulse when a search ends.
REQ-009 result  output  8  resolved target value; holds until the next accepted start.
REQ-010 err  output  1  high with done when a search is aborted on an invalid cmp code; holds until the next accepted start.

Function
REQ-011 The block SHALL implement FSM states IDLE, TRY and DONE, with a 3-bit bit index idx.
REQ-012 IDLE: guess=8'h00, busy=0, done=0; start=1 SHALL give, next cycle, TRY with guess=8'h80 and idx=7, result=0 and err=0.
REQ-013 TRY SHALL sample cmp every cycle and resolve one bit per cycle, MSB first.
REQ-014 TRY, cmp==3'b010: go to DONE with result=guess and err=0 (early exit).
REQ-015 TRY, cmp==3'b100: keep guess[idx]; cmp==3'b001: clear guess[idx].
REQ-016 TRY, idx>0 and not equal: also set guess[idx-1] and decrement idx.
REQ-017 TRY, idx==0 and not equal: go to DONE with result = guess after the REQ-015 update and err=0.
REQ-018 TRY, cmp not one-hot (000, 011, 101, 110, 111): go to DONE with result=8'h00 and err=1.
REQ-019 Latency SHALL be at most 8 TRY cycles; done SHALL be asserted 2 to 9 cycles after the start cycle.
REQ-020 DONE: done=1 and busy=0 for exactly one cycle, then IDLE; guess returns to 8'h00 in IDLE.
REQ-021 start SHALL be ignored in TRY and DONE, with no queuing; start in IDLE the cycle after DONE SHALL be accepted.
REQ-022 guess SHALL change only on clock edges; no output SHALL depend combinationally on cmp.

Reset
REQ-023 rst=1 SHALL force IDLE, idx=0, guess=8'h00, result=8'h00, busy=0, done=0, err=0 on the next edge.
REQ-024 Reset SHALL take priority over start and cmp, including mid-search; no done pulse SHALL follow an aborted search.

Verification (bench models the comparator against target T; start pulsed at cycle 0)
REQ-025 T=8'h80 -> cycle 1 guess=80 with equal; cycle 2 done=1, result=80, err=0.
REQ-026 T=8'h00 -> guesses 80,40,20,10,08,04,02,01 in cycles 1-8; cycle 9 done=1, result=00.
REQ-027 T=8'hFF -> guesses 80,C0,E0,F0,F8,FC,FE,FF; equal in cycle 8; cycle 9 done=1, result=FF.
REQ-028 T=8'h02 -> guesses 80,40,20,10,08,04,02, equal in cycle 7; cycle 8 done=1, result=02; start re-pulsed in cycles 3 and 8 -> ignored, no second search.
REQ-029 cmp forced to 3'b000 in cycle 1 -> cycle 2 done=1, err=1, result=00; the next start clears err.
REQ-030 T=8'hF0, rst=1 in cycle 4 -> cycle 5 IDLE, all outputs zero, no done; start at cycle 6 -> normal search, result=F0.
